// File: rtl/avmm_rw_agent_mem_if.sv
// Avalon-MM bus bundle between the HLS host (master) and the 64-bit agent memory (slave).
interface avmm_rw_agent_mem_if;
  logic [63:0] avs_address;
  logic [7:0]  avs_byteenable;
  logic        avs_read;
  logic        avs_write;
  logic [63:0] avs_writedata;
  logic [63:0] avs_readdata;
  logic        avs_readdatavalid;

  modport master (
    output avs_address, avs_byteenable, avs_read, avs_write, avs_writedata,
    input  avs_readdata, avs_readdatavalid
  );

  modport slave (
    input  avs_address, avs_byteenable, avs_read, avs_write, avs_writedata,
    output avs_readdata, avs_readdatavalid
  );
endinterface

// File: rtl/avmm_rw_agent_mem.sv
// Fixed-latency Avalon-MM agent memory: byte-enable writes, pipelined reads, sticky error flags.
// Optional access counters are built only when AVMM_AGENT_STATS_EN is defined.
module avmm_rw_agent_mem #(
  parameter int unsigned DEPTH        = 1024,
  parameter int unsigned READ_LATENCY = 2,
  parameter logic [63:0] BASE_ADDR    = 64'h0
) (
  input  logic                clock,
  input  logic                resetn,
  avmm_rw_agent_mem_if.slave  avs,
  output logic                oob_err,
  output logic                proto_err,
  output logic [31:0]         rd_count,
  output logic [31:0]         wr_count
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam logic [63:0] SPAN = 64'(DEPTH) << 3;

  logic [63:0] mem [DEPTH];

  logic [63:0]             off;
  logic                    in_range;
  logic [AW-1:0]           word;
  logic                    wr_en;
  logic [63:0]             rd_sample;
  logic [READ_LATENCY-1:0] vld_pipe;
  logic [63:0]             dat_pipe [READ_LATENCY];

  always_comb begin
    off       = avs.avs_address - BASE_ADDR;
    in_range  = (avs.avs_address >= BASE_ADDR) && (off < SPAN);
    word      = off[AW+2:3];
    // nothing is accepted while reset is held, including writes into the unreset array
    wr_en     = avs.avs_write && in_range && resetn;
    rd_sample = in_range ? mem[word] : '0;
  end

  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int unsigned b = 0; b < 8; b++) begin
        if (avs.avs_byteenable[b]) mem[word][8*b +: 8] <= avs.avs_writedata[8*b +: 8];
      end
    end
  end

  // Final data stage loads only on a valid beat so readdata holds between returns.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      vld_pipe <= '0;
      for (int unsigned i = 0; i < READ_LATENCY; i++) dat_pipe[i] <= '0;
    end else begin
      vld_pipe[0] <= avs.avs_read;
      if (READ_LATENCY > 1 || avs.avs_read) dat_pipe[0] <= rd_sample;
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        if (i < READ_LATENCY - 1 || vld_pipe[i-1]) dat_pipe[i] <= dat_pipe[i-1];
      end
    end
  end

  assign avs.avs_readdata      = dat_pipe[READ_LATENCY-1];
  assign avs.avs_readdatavalid = vld_pipe[READ_LATENCY-1];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      oob_err   <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      if ((avs.avs_read || avs.avs_write) && !in_range) oob_err <= 1'b1;
      if (avs.avs_read && avs.avs_write) proto_err <= 1'b1;
    end
  end

`ifdef AVMM_AGENT_STATS_EN
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      if (avs.avs_read)  rd_count <= rd_count + 32'd1;
      if (avs.avs_write) wr_count <= wr_count + 32'd1;
    end
  end
`else
  assign rd_count = '0;
  assign wr_count = '0;
`endif

endmodule

// File: tb/tb_avmm_rw_agent_mem.sv
// Randomised self-checking bench for avmm_rw_agent_mem against a queue/array reference model.
module tb_avmm_rw_agent_mem;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned L     = 3;
  localparam logic [63:0] BASE  = 64'h100;
  localparam logic [63:0] SPAN  = 64'(DEPTH) * 64'd8;
`ifdef AVMM_AGENT_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        oob_err, proto_err;
  logic [31:0] rd_count, wr_count;

  avmm_rw_agent_mem_if avs_bus ();

  avmm_rw_agent_mem #(.DEPTH(DEPTH), .READ_LATENCY(L), .BASE_ADDR(BASE)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .avs       (avs_bus.slave),
    .oob_err   (oob_err),
    .proto_err (proto_err),
    .rd_count  (rd_count),
    .wr_count  (wr_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          due;
    logic [63:0] data;
  } rd_t;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  bit          chk_en = 1'b0;
  logic [63:0] mdl_mem [DEPTH];
  rd_t         pend [$];
  logic [63:0] exp_rdata = '0;
  bit          exp_vld = 1'b0, exp_oob = 1'b0, exp_proto = 1'b0;
  int unsigned n_rd = 0, n_wr = 0;
  logic [63:0] seen_d [$];
  int          seen_c [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h time=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: a read at edge k returns the pre-write word at edge k+L-1 (cycle t+L).
  task automatic model_step();
    logic [63:0] a, mask, data;
    bit          in;
    int          w;
    cyc++;
    if (!resetn) begin
      pend.delete();
      exp_rdata = '0; exp_vld = 1'b0; exp_oob = 1'b0; exp_proto = 1'b0;
      n_rd = 0; n_wr = 0;
      return;
    end
    a  = avs_bus.avs_address;
    in = (a >= BASE) && ((a - BASE) < SPAN);
    w  = in ? int'((a - BASE) / 64'd8) : 0;
    if (avs_bus.avs_read) begin
      pend.push_back('{due: cyc + int'(L) - 1, data: in ? mdl_mem[w] : 64'h0});
      n_rd++;
    end
    if (avs_bus.avs_write) begin
      n_wr++;
      if (in) begin
        mask = '0;
        for (int b = 0; b < 8; b++) if (avs_bus.avs_byteenable[b]) mask = mask | (64'hFF << (8 * b));
        data = mdl_mem[w];
        mdl_mem[w] = (data & ~mask) | (avs_bus.avs_writedata & mask);
      end
    end
    if ((avs_bus.avs_read || avs_bus.avs_write) && !in) exp_oob = 1'b1;
    if (avs_bus.avs_read && avs_bus.avs_write) exp_proto = 1'b1;
    exp_vld = 1'b0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      exp_rdata = pend[0].data;
      exp_vld   = 1'b1;
      void'(pend.pop_front());
    end
  endtask

  initial forever begin
    @(posedge clock);
    model_step();
  end

  initial forever begin
    @(negedge clock);
    if (avs_bus.avs_readdatavalid) begin
      seen_d.push_back(avs_bus.avs_readdata);
      seen_c.push_back(cyc);
    end
    if (chk_en) begin
      if (!resetn) begin
        chk("rst_rdata",  avs_bus.avs_readdata, 64'h0);
        chk("rst_rvalid", 64'(avs_bus.avs_readdatavalid), 64'h0);
        chk("rst_oob",    64'(oob_err), 64'h0);
        chk("rst_proto",  64'(proto_err), 64'h0);
        chk("rst_rdcnt",  64'(rd_count), 64'h0);
        chk("rst_wrcnt",  64'(wr_count), 64'h0);
      end else begin
        chk("rdata",  avs_bus.avs_readdata, exp_rdata);
        chk("rvalid", 64'(avs_bus.avs_readdatavalid), 64'(exp_vld));
        chk("oob",    64'(oob_err), 64'(exp_oob));
        chk("proto",  64'(proto_err), 64'(exp_proto));
        chk("rdcnt",  64'(rd_count), STATS ? 64'(n_rd) : 64'h0);
        chk("wrcnt",  64'(wr_count), STATS ? 64'(n_wr) : 64'h0);
      end
    end
  end

  task automatic drive(input bit rd, input bit wr, input logic [63:0] a,
                       input logic [7:0] be, input logic [63:0] wd);
    avs_bus.avs_read       = rd;
    avs_bus.avs_write      = wr;
    avs_bus.avs_address    = a;
    avs_bus.avs_byteenable = be;
    avs_bus.avs_writedata  = wd;
    @(posedge clock);
    #2;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 64'h0, 8'h00, 64'h0);
  endtask

  task automatic wr_word(input logic [63:0] a, input logic [7:0] be, input logic [63:0] wd);
    drive(1'b0, 1'b1, a, be, wd);
  endtask

  // Issues one read and checks exactly one return, L cycles later.
  task automatic read_word(input string name, input logic [63:0] a, input logic [63:0] exp);
    int k;
    seen_d.delete();
    seen_c.delete();
    drive(1'b1, 1'b0, a, 8'h00, 64'h0);
    k = cyc;
    idle(int'(L));
    chk({name, "_beats"}, 64'(seen_d.size()), 64'd1);
    if (seen_d.size() == 1) begin
      chk({name, "_lat"},  64'(seen_c[0] - k + 1), 64'(L));
      chk({name, "_data"}, seen_d[0], exp);
    end
  endtask

  function automatic logic [63:0] rand_addr();
    int unsigned sel;
    sel = $urandom_range(0, 7);
    if (sel == 0) return BASE + SPAN + 64'($urandom_range(0, 255));
    if (sel == 1) return BASE - 64'($urandom_range(1, 256));
    return BASE + (64'($urandom_range(0, DEPTH - 1)) << 3) + 64'($urandom_range(0, 7));
  endfunction

  initial begin
    int k;
    // T1: reset held with random traffic
    for (int i = 0; i < 3; i++) begin
      drive(1'($urandom), 1'($urandom), rand_addr(), 8'($urandom), {$urandom(), $urandom()});
      chk_en = 1'b1;
    end
    chk("t1_rdata", avs_bus.avs_readdata, 64'h0);
    chk("t1_oob",   64'(oob_err), 64'h0);
    chk("t1_rdcnt", 64'(rd_count), 64'h0);
    resetn = 1'b1;
    idle(1);

    for (int i = 0; i < int'(DEPTH); i++)
      wr_word(BASE + 64'(i) * 64'd8, 8'hFF, {$urandom(), $urandom()});

    // T2: byte-enable merge
    wr_word(BASE + 64'h10, 8'hFF, 64'h1122334455667788);
    wr_word(BASE + 64'h10, 8'h0F, 64'hAAAAAAAA_BBBBBBBB);
    read_word("t2", BASE + 64'h10, 64'h11223344BBBBBBBB);
    wr_word(BASE + 64'h18, 8'hA5, 64'hFFFFFFFF_FFFFFFFF);
    wr_word(BASE + 64'h18, 8'h5A, 64'h0);
    read_word("t2b", BASE + 64'h1F, 64'hFF00FF0000FF00FF);

    // T3: eight back-to-back reads
    for (int i = 0; i < 8; i++) wr_word(BASE + 64'(i) * 64'd8, 8'hFF, 64'(i * 3));
    seen_d.delete();
    seen_c.delete();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, BASE + 64'(i) * 64'd8, 8'h00, 64'h0);
      if (i == 0) k = cyc;
    end
    idle(int'(L));
    chk("t3_beats", 64'(seen_d.size()), 64'd8);
    for (int i = 0; i < 8 && i < seen_d.size(); i++) begin
      chk("t3_data", seen_d[i], 64'(i * 3));
      chk("t3_cyc",  64'(seen_c[i] - k + 1), 64'(int'(L) + i));
    end

    // T4: same-cycle read and write
    chk("t4_proto_pre", 64'(proto_err), 64'h0);
    wr_word(BASE + 64'd40, 8'hFF, 64'd1);
    seen_d.delete();
    drive(1'b1, 1'b1, BASE + 64'd40, 8'hFF, 64'd2);
    idle(int'(L));
    chk("t4_beats", 64'(seen_d.size()), 64'd1);
    if (seen_d.size() == 1) chk("t4_old", seen_d[0], 64'd1);
    chk("t4_proto", 64'(proto_err), 64'h1);
    read_word("t4_new", BASE + 64'd40, 64'd2);

    // T5: out of range above and below the window
    chk("t5_oob_pre", 64'(oob_err), 64'h0);
    wr_word(BASE, 8'hFF, 64'h0123456789ABCDEF);
    wr_word(BASE + SPAN, 8'hFF, 64'hDEADBEEF_DEADBEEF);
    read_word("t5_hi", BASE + SPAN, 64'h0);
    chk("t5_oob", 64'(oob_err), 64'h1);
    read_word("t5_mem0", BASE, 64'h0123456789ABCDEF);
    read_word("t5_lo", BASE - 64'd8, 64'h0);

    // Random traffic, checked every cycle by the model
    for (int i = 0; i < 400; i++)
      drive(($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0), rand_addr(),
            8'($urandom), {$urandom(), $urandom()});
    idle(int'(L));

    // T6: reset one cycle after a read
    seen_d.delete();
    drive(1'b1, 1'b0, BASE + 64'd8, 8'h00, 64'h0);
    resetn = 1'b0;
    idle(2);
    resetn = 1'b1;
    idle(int'(L) + 2);
    chk("t6_killed", 64'(seen_d.size()), 64'd0);
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, rand_addr(), 8'h00, 64'h0);
    for (int i = 0; i < 3; i++) wr_word(rand_addr(), 8'($urandom), {$urandom(), $urandom()});
    idle(1);
    chk("t6_rdcnt", 64'(rd_count), STATS ? 64'd5 : 64'd0);
    chk("t6_wrcnt", 64'(wr_count), STATS ? 64'd3 : 64'd0);
    idle(int'(L) + 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
